// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define ADDER_FLAGS_EN to build the {overflow, negative, zero} flag logic; otherwise flags reads 3'b000.
module pipelined_cla_adder #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [2:0]       flags
);

    localparam int NG = WIDTH / GROUPSIZE;

    generate
        if (!(GROUPSIZE == 1 || GROUPSIZE == 2 || GROUPSIZE == 4 || GROUPSIZE == 8)
            || (WIDTH < 1) || (WIDTH % GROUPSIZE != 0)) begin : g_bad_cfg
            $fatal(1, "pipelined_cla_adder: illegal WIDTH/GROUPSIZE combination");
        end
    endgenerate

    // ---------------- Stage 1: operand conditioning and group (G, P) ----------------
    logic [WIDTH-1:0] bp_d, g_d, p_d;
    logic [NG-1:0]    grp_g_d, grp_p_d;

    assign bp_d = b ^ {WIDTH{sub}};
    assign g_d  = a & bp_d;
    assign p_d  = a | bp_d;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp_gp
            logic grp_g;
            logic term;
            always_comb begin
                grp_g = 1'b0;
                term  = 1'b0;
                for (int j = 0; j < GROUPSIZE; j++) begin
                    term = g_d[gi*GROUPSIZE + j];
                    for (int m = j + 1; m < GROUPSIZE; m++) begin
                        term = term & p_d[gi*GROUPSIZE + m];
                    end
                    grp_g = grp_g | term;
                end
            end
            assign grp_g_d[gi] = grp_g;
            assign grp_p_d[gi] = &p_d[gi*GROUPSIZE +: GROUPSIZE];
        end
    endgenerate

    logic [WIDTH-1:0] a_q, bp_q, g_q, p_q;
    logic [NG-1:0]    grp_g_q, grp_p_q;
    logic             c0_q;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic             s2_adv, accept, s1_load, s2_load;

    // Handshake: in_ready depends only on state and out_ready, never on in_valid.
    assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign accept   = in_valid & in_ready;
    assign s1_load  = accept & ~flush;
    assign s2_load  = s2_adv & ~flush;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush)        s1_valid_d = 1'b0;
        else if (accept)  s1_valid_d = 1'b1;
        else if (s2_adv)  s1_valid_d = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (s2_adv)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            bp_q    <= '0;
            g_q     <= '0;
            p_q     <= '0;
            grp_g_q <= '0;
            grp_p_q <= '0;
            c0_q    <= 1'b0;
        end else if (s1_load) begin
            a_q     <= a;
            bp_q    <= bp_d;
            g_q     <= g_d;
            p_q     <= p_d;
            grp_g_q <= grp_g_d;
            grp_p_q <= grp_p_d;
            c0_q    <= sub | cin;
        end
    end

    // ---------------- Stage 2: flattened group carries, in-group carries, sum ----------------
    logic [NG:0]      c_grp;
    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign c_grp[0] = c0_q;

    generate
        for (gi = 0; gi < NG; gi++) begin : g_carry
            // Each group carry is a sum-of-products of all lower (G, P) pairs and c0.
            logic c_next;
            logic term;
            always_comb begin
                c_next = c0_q & (&grp_p_q[gi:0]);
                term   = 1'b0;
                for (int j = 0; j <= gi; j++) begin
                    term = grp_g_q[j];
                    for (int m = j + 1; m <= gi; m++) begin
                        term = term & grp_p_q[m];
                    end
                    c_next = c_next | term;
                end
            end
            assign c_grp[gi+1] = c_next;

            logic [GROUPSIZE:0] cc;
            always_comb begin
                cc    = '0;
                cc[0] = c_grp[gi];
                for (int j = 0; j < GROUPSIZE; j++) begin
                    cc[j+1] = g_q[gi*GROUPSIZE + j] | (p_q[gi*GROUPSIZE + j] & cc[j]);
                end
            end
            assign carry_vec[gi*GROUPSIZE +: GROUPSIZE] = cc[GROUPSIZE-1:0];
        end
    endgenerate

    assign sum_d  = a_q ^ bp_q ^ carry_vec;
    assign cout_d = c_grp[NG];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (s2_load) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

`ifdef ADDER_FLAGS_EN
    logic [2:0] flags_d, flags_q;

    assign flags_d = {(a_q[WIDTH-1] == bp_q[WIDTH-1]) & (sum_d[WIDTH-1] != a_q[WIDTH-1]),
                      sum_d[WIDTH-1],
                      (sum_d == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       flags_q <= 3'b000;
        else if (s2_load) flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = 3'b000;
`endif

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised self-checking bench: a queue-based transaction model predicts every output cycle.
// Directed beats pin the model with hand-computed literals; extra instances cover other group sizes.
module tb_pipelined_cla_adder;

    localparam int W = 32;

`ifdef ADDER_FLAGS_EN
    localparam logic [2:0] F_ZERO = 3'b001;
    localparam logic [2:0] F_NEG  = 3'b010;
    localparam logic [2:0] F_OVN  = 3'b110;
    localparam bit         FLAGS_ON = 1'b1;
`else
    localparam logic [2:0] F_ZERO = 3'b000;
    localparam logic [2:0] F_NEG  = 3'b000;
    localparam logic [2:0] F_OVN  = 3'b000;
    localparam bit         FLAGS_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         sub = 1'b0, cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic [2:0]   flags;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUPSIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .flags(flags)
    );

    // Alternate geometries, all fed all-ones + 1.
    logic        xv = 1'b0;
    logic        x_one = 1'b1;
    logic        x_zero = 1'b0;
    logic [15:0] a16 = '1, b16 = 16'd1, s16;
    logic [31:0] a32 = '1, b32 = 32'd1, s32;
    logic [63:0] a64 = '1, b64 = 64'd1, s64;
    logic        ir16, ir32, ir64, ov16, ov32, ov64, c16, c32, c64;
    logic [2:0]  f16, f32, f64;

    pipelined_cla_adder #(.WIDTH(16), .GROUPSIZE(1)) u_g1 (
        .clk(clk), .rst_n(rst_n), .flush(x_zero), .in_valid(xv), .in_ready(ir16),
        .a(a16), .b(b16), .sub(x_zero), .cin(x_zero), .out_valid(ov16), .out_ready(x_one),
        .sum(s16), .cout(c16), .flags(f16)
    );
    pipelined_cla_adder #(.WIDTH(32), .GROUPSIZE(2)) u_g2 (
        .clk(clk), .rst_n(rst_n), .flush(x_zero), .in_valid(xv), .in_ready(ir32),
        .a(a32), .b(b32), .sub(x_zero), .cin(x_zero), .out_valid(ov32), .out_ready(x_one),
        .sum(s32), .cout(c32), .flags(f32)
    );
    pipelined_cla_adder #(.WIDTH(64), .GROUPSIZE(8)) u_g8 (
        .clk(clk), .rst_n(rst_n), .flush(x_zero), .in_valid(xv), .in_ready(ir64),
        .a(a64), .b(b64), .sub(x_zero), .cin(x_zero), .out_valid(ov64), .out_ready(x_one),
        .sum(s64), .cout(c64), .flags(f64)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic [2:0]   f;
        int           e;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] outlog[$];
    int           edge_cnt = 0;

    // Plain arithmetic reference for one beat.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mcin, input int e);
        exp_t         r;
        logic [W-1:0] bp;
        logic [W:0]   t;
        bp  = msub ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, (msub | mcin)};
        r.s = t[W-1:0];
        r.c = t[W];
        r.f = 3'b000;
        if (FLAGS_ON)
            r.f = {(ma[W-1] == bp[W-1]) && (r.s[W-1] != ma[W-1]), r.s[W-1], (r.s == '0)};
        r.e = e;
        return r;
    endfunction

    // Transaction monitor: observes handshakes as they are at each edge.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    outlog.push_back(sum);
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (in_valid && in_ready) q.push_back(model(a, b, sub, cin, edge_cnt));
            end
        end
    end

    // Compare process: every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", {63'd0, out_valid}, 64'd0);
                check("rst_in_ready", {63'd0, in_ready}, 64'd1);
                check("rst_sum", {32'd0, sum}, 64'd0);
                check("rst_cout_flags", {60'd0, cout, flags}, 64'd0);
            end else begin
                bit expv;
                expv = (q.size() > 0) && (edge_cnt >= q[0].e + 1);
                check("out_valid", {63'd0, out_valid}, {63'd0, expv});
                check("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) || out_ready});
                if (expv && out_valid) begin
                    check("sum", {32'd0, sum}, {32'd0, q[0].s});
                    check("cout", {63'd0, cout}, {63'd0, q[0].c});
                    check("flags", {61'd0, flags}, {61'd0, q[0].f});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One beat with out_ready=1: accepted at the next edge, visible after the following one.
    task automatic one_beat(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tsub, input logic [W-1:0] es, input logic ec,
                            input logic [2:0] ef);
        a = ta; b = tb_; sub = tsub; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({name, "_sum"}, {32'd0, sum}, {32'd0, es});
        check({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
        check({name, "_flags"}, {61'd0, flags}, {61'd0, ef});
        $display("beat %s: a=0x%08h b=0x%08h sub=%0b -> sum=0x%08h cout=%0b flags=%03b",
                 name, ta, tb_, tsub, sum, cout, flags);
    endtask

    initial begin
        int  i;
        bit  saw_low;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed literal beats.
        one_beat("ones_plus1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, F_ZERO);
        one_beat("5_minus_7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, F_NEG);
        one_beat("7_minus_5", 32'd7, 32'd5, 1'b1, 32'h2, 1'b1, 3'b000);
        one_beat("max_plus1", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, F_OVN);
        tick(); tick();

        // Stream 1..6 with a 4-cycle consumer stall.
        outlog.delete();
        i = 1;
        saw_low = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = (i <= 6);
            a         = i;
            b         = i;
            sub       = 1'b0;
            out_ready = !(cyc >= 3 && cyc < 7);
            #1;
            if (!in_ready) saw_low = 1'b1;
            if (in_valid && in_ready) begin
                $display("stream accept a=%0d b=%0d", i, i);
                i++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_in_ready_dropped", {63'd0, saw_low}, 64'd1);
        check("stream_count", outlog.size(), 64'd6);
        for (int k = 0; k < 6 && k < outlog.size(); k++)
            check("stream_order", {32'd0, outlog[k]}, 64'(2 * (k + 1)));

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1; a = 32'd10; b = 32'd20;
        tick(); tick();
        in_valid = 1'b0;
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_immediate_valid", {63'd0, out_valid}, 64'd0);
        check("reset_immediate_ready", {63'd0, in_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_reset_quiet", {63'd0, out_valid}, 64'd0);
        end
        one_beat("after_reset", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 3'b000);

        // Flush with two beats in flight and a beat offered in the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1; a = 32'd11; b = 32'd11;
        tick(); tick();
        flush = 1'b1; a = 32'd99;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("flush_no_ghost", {63'd0, out_valid}, 64'd0);
        one_beat("after_flush", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 3'b000);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 5))
                0:       begin a = 32'hFFFF_FFFF; b = $urandom_range(0, 2); end
                1:       begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 2); end
                2:       begin a = $urandom; b = a; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            sub = $urandom_range(0, 1);
            cin = $urandom_range(0, 1);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        $display("random phase done: %0d checks so far", checks);

        // Other geometries: all-ones + 1 must wrap to zero with carry-out.
        xv = 1'b1;
        tick();
        xv = 1'b0;
        tick();
        check("g1_valid", {63'd0, ov16}, 64'd1);
        check("g1_sum_cout", {47'd0, c16, s16}, {47'd0, 1'b1, 16'd0});
        check("g1_flags", {61'd0, f16}, {61'd0, F_ZERO});
        check("g2_valid", {63'd0, ov32}, 64'd1);
        check("g2_sum_cout", {31'd0, c32, s32}, {31'd0, 1'b1, 32'd0});
        check("g2_flags", {61'd0, f32}, {61'd0, F_ZERO});
        check("g8_valid", {63'd0, ov64}, 64'd1);
        check("g8_sum", s64, 64'd0);
        check("g8_cout", {63'd0, c64}, 64'd1);
        check("g8_flags", {61'd0, f64}, {61'd0, F_ZERO});
        check("g_ready", {61'd0, ir16, ir32, ir64}, 64'd7);
        $display("geometries: g1 sum=0x%04h g2 sum=0x%08h g8 sum=0x%016h", s16, s32, s64);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
